// File: rtl/mvm_pkg.sv
// mvm_pkg: shared definitions for the matrix-vector-multiply sequencer.
// Holds the FSM state encoding, the command opcodes and the fixed
// datapath latency (memory read + multiply register).
package mvm_pkg;

   typedef enum logic [3:0] {
      IDLE,
      LOAD_A,
      LOAD_X,
      CLR,
      MAC,
      DRAIN,
      WRITE_Y,
      WAIT_Y,
      OUT
   } state_t;

   localparam logic [1:0] OP_LOAD_A = 2'd0;
   localparam logic [1:0] OP_LOAD_X = 2'd1;
   localparam logic [1:0] OP_RUN    = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;

   localparam int DP_LAT = 2;

endpackage

// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: handshaked sequencer for the K-row matrix-vector-multiply
// engine. Loads A (row-major, K*K beats) and X (K beats), runs the K-cycle
// MAC across all rows, captures each row's sum into its Y memory and
// streams the K results out.
// Optional feature: define MVM_SEQ_ABORT_EN to add the `abort` input.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a command; only state with cmd_ready high
//   LOAD_A  | K*K A beats, beat n -> row n/K, column n%K
//   LOAD_X  | K X beats, address = cnt
//   CLR     | one cycle: clear accumulators, present address 0
//   MAC     | cnt 1..K-1 presented as A/X address
//   DRAIN   | DP_LAT+G cycles letting the last product reach add_r
//   WRITE_Y | one cycle: add_r holds the exact sum, capture into Y
//   WAIT_Y  | one cycle for the Y memory read-before-write latency
//   OUT     | K result beats on the out_valid/out_ready handshake
module mvm_seq_ctrl
   import mvm_pkg::*;
#(
   parameter int K     = 4,
   parameter int G     = 0,
   parameter int LOG_K = $clog2(K)
) (
   input  logic             clk,
   input  logic             reset,
`ifdef MVM_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [LOG_K-1:0] addr_x,
   output logic             wr_en_x,
   output logic [LOG_K-1:0] addr_a,
   output logic [K-1:0]     wr_en_a,
   output logic             clear_acc,
   output logic             wr_en_y,
   output logic [LOG_K-1:0] sel_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CW = $clog2(K*K);
   localparam logic [CW-1:0] K_CW           = CW'(K);
   localparam logic [CW-1:0] CNT_A_LAST     = CW'(K*K - 1);
   localparam logic [CW-1:0] CNT_K_LAST     = CW'(K - 1);
   localparam logic [CW-1:0] CNT_DRAIN_LAST = CW'(DP_LAT + G - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_ok_q, a_ok_d;
   logic          x_ok_q, x_ok_d;
   logic          err_q, err_d;
   logic          done_q, done_d;

   logic [LOG_K-1:0] cnt_lo;
   logic [LOG_K-1:0] a_row;
   logic [LOG_K-1:0] a_col;

   assign cnt_lo = LOG_K'(cnt_q);
   assign a_row  = LOG_K'(cnt_q / K_CW);
   assign a_col  = LOG_K'(cnt_q % K_CW);

   // Next-state, counter and operand-valid flag logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_ok_d  = a_ok_q;
      x_ok_d  = x_ok_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               cnt_d = '0;
               case (cmd_op)
                  OP_LOAD_A: state_d = LOAD_A;
                  OP_LOAD_X: state_d = LOAD_X;
                  OP_RUN: begin
                     if (a_ok_q && x_ok_q) state_d = CLR;
                     else                  err_d   = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
            end
         end
         LOAD_A: begin
            if (in_valid) begin
               if (cnt_q == CNT_A_LAST) begin
                  a_ok_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         LOAD_X: begin
            if (in_valid) begin
               if (cnt_q == CNT_K_LAST) begin
                  x_ok_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         CLR: begin
            // Address 0 was presented in CLR, so MAC starts at 1.
            state_d = MAC;
            cnt_d   = CW'(1);
         end
         MAC: begin
            if (cnt_q == CNT_K_LAST) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_DRAIN_LAST) begin
               state_d = WRITE_Y;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WRITE_Y: begin
            state_d = WAIT_Y;
            cnt_d   = '0;
         end
         WAIT_Y: begin
            state_d = OUT;
            cnt_d   = '0;
         end
         OUT: begin
            if (out_ready) begin
               if (cnt_q == CNT_K_LAST) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
`ifdef MVM_SEQ_ABORT_EN
      // A partially loaded operand is no longer trustworthy; a run in
      // progress leaves both operands intact.
      if (abort) begin
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = 1'b0;
         done_d  = 1'b0;
         if (state_q == LOAD_A) a_ok_d = 1'b0;
         if (state_q == LOAD_X) x_ok_d = 1'b0;
      end
`endif
   end

   // State, counter and pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_ok_q  <= 1'b0;
         x_ok_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_ok_q  <= a_ok_d;
         x_ok_q  <= x_ok_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   // Output decode from registered state, counter and in_valid.
   always_comb begin
      cmd_ready = (state_q == IDLE);
`ifdef MVM_SEQ_ABORT_EN
      cmd_ready = (state_q == IDLE) && !abort;
`endif
      busy      = (state_q != IDLE);
      in_ready  = 1'b0;
      addr_x    = '0;
      wr_en_x   = 1'b0;
      addr_a    = '0;
      wr_en_a   = '0;
      clear_acc = 1'b0;
      wr_en_y   = 1'b0;
      sel_y     = '0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      err       = err_q;
      done      = done_q;
      unique case (state_q)
         LOAD_A: begin
            in_ready = 1'b1;
            addr_a   = a_col;
            wr_en_a  = K'(in_valid) << a_row;
         end
         LOAD_X: begin
            in_ready = 1'b1;
            addr_x   = cnt_lo;
            wr_en_x  = in_valid;
         end
         CLR: begin
            clear_acc = 1'b1;
         end
         MAC: begin
            addr_x = cnt_lo;
            addr_a = cnt_lo;
         end
         WRITE_Y: begin
            wr_en_y = 1'b1;
         end
         OUT: begin
            sel_y     = cnt_lo;
            out_valid = 1'b1;
            out_last  = (cnt_q == CNT_K_LAST);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb_mvm_seq_ctrl: scoreboard bench for mvm_seq_ctrl with a behavioural
// model of the K datapaths (A/X memories, mult_r, add_r, Y memory).
module tb_mvm_seq_ctrl;
   import mvm_pkg::*;

   localparam int K     = 4;
   localparam int G     = 0;
   localparam int LOG_K = $clog2(K);

   localparam int EV_WRX  = 1;
   localparam int EV_WY   = 2;
   localparam int EV_BEAT = 3;
   localparam int EV_ERR  = 4;
   localparam int EV_DONE = 5;

   typedef struct {
      int kind;
      int a;
      int b;
      int c;
   } ev_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             in_valid;
   logic             in_ready;
   logic [LOG_K-1:0] addr_x;
   logic             wr_en_x;
   logic [LOG_K-1:0] addr_a;
   logic [K-1:0]     wr_en_a;
   logic             clear_acc;
   logic             wr_en_y;
   logic [LOG_K-1:0] sel_y;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             err;
   logic signed [7:0] data_in;

   ev_t exp_q[$];
   int  n_pass  = 0;
   int  n_total = 0;
   int  cyc     = 0;
   int  clr_cyc = 0;

   logic signed [7:0] av[K*K];
   logic signed [7:0] xv[K];
   int                exp_y[K];

   always #5 clk = ~clk;

   mvm_seq_ctrl #(.K(K), .G(G), .LOG_K(LOG_K)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MVM_SEQ_ABORT_EN
      .abort     (1'b0),
`endif
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .addr_x    (addr_x),
      .wr_en_x   (wr_en_x),
      .addr_a    (addr_a),
      .wr_en_a   (wr_en_a),
      .clear_acc (clear_acc),
      .wr_en_y   (wr_en_y),
      .sel_y     (sel_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Datapath model: synchronous memory read, mult_r, add_r, Y capture.
   logic signed [7:0]  ma[K][K];
   logic signed [7:0]  mx[K];
   logic signed [7:0]  a_rd[K];
   logic signed [7:0]  x_rd;
   logic signed [15:0] mult_r[K];
   logic signed [15:0] add_r[K];
   logic signed [15:0] ym[K];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (wr_en_x) mx[addr_x] <= data_in;
      x_rd <= mx[addr_x];
      for (int r = 0; r < K; r++) begin
         if (wr_en_a[r]) ma[r][addr_a] <= data_in;
         a_rd[r] <= ma[r][addr_a];
         if (clear_acc) begin
            mult_r[r] <= '0;
            add_r[r]  <= '0;
         end else begin
            mult_r[r] <= a_rd[r] * x_rd;
            add_r[r]  <= add_r[r] + mult_r[r];
         end
         if (wr_en_y) ym[r] <= add_r[r];
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic push(input int kind, input int a, input int b, input int c);
      ev_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      e.c    = c;
      exp_q.push_back(e);
   endtask

   task automatic observe(input int kind, input int a, input int b, input int c);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_total++;
         $display("FAIL unexpected_event: got kind %0d (a=%0d b=%0d c=%0d), required none",
                  kind, a, b, c);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         if (kind == e.kind) begin
            chk($sformatf("ev%0d_a", kind), a, e.a);
            chk($sformatf("ev%0d_b", kind), b, e.b);
            chk($sformatf("ev%0d_c", kind), c, e.c);
         end
      end
   endtask

   // Monitor: samples DUT outputs mid-cycle and scores each event.
   always @(negedge clk) begin
      if (!reset) begin
         if (clear_acc) clr_cyc = cyc;
         if (wr_en_x) observe(EV_WRX, int'(addr_x), 0, 0);
         if (wr_en_y) observe(EV_WY, cyc - clr_cyc, 0, 0);
         if (out_valid && out_ready)
            observe(EV_BEAT, int'(sel_y), int'(out_last), int'(ym[sel_y]));
         if (err)  observe(EV_ERR, 0, 0, 0);
         if (done) observe(EV_DONE, 0, 0, 0);
      end
   end

   task automatic do_cmd(input logic [1:0] op);
      for (int i = 0; i < 50 && !cmd_ready; i++) begin
         @(posedge clk); #1;
      end
      chk("cmd_ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 80 && busy; i++) begin
         @(posedge clk); #1;
      end
      chk(name, int'(busy), 0);
   endtask

   task automatic load_x(input bit gappy, input bit poke);
      for (int i = 0; i < K; i++) push(EV_WRX, i, 0, 0);
      do_cmd(OP_LOAD_X);
      for (int i = 0; i < K; i++) begin
         data_in  = xv[i];
         in_valid = 1'b1;
         if (i == K-1) cmd_valid = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (gappy) begin
            if (poke && i == 0) begin
               cmd_valid = 1'b1;
               cmd_op    = OP_RSVD;
            end
            @(posedge clk); #1;
         end
      end
      chk("load_x_back_idle", int'(busy), 0);
   endtask

   task automatic load_a();
      do_cmd(OP_LOAD_A);
      for (int n = 0; n < K*K; n++) begin
         data_in  = av[n];
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("load_a_back_idle", int'(busy), 0);
   endtask

   task automatic run(input bit hold);
      push(EV_WY, K + 2 + G, 0, 0);
      for (int r = 0; r < K; r++) push(EV_BEAT, r, (r == K-1) ? 1 : 0, exp_y[r]);
      push(EV_DONE, 0, 0, 0);
      out_ready = !hold;
      do_cmd(OP_RUN);
      if (hold) begin
         for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk); #1;
         end
         chk("hold_first_valid", int'(out_valid), 1);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         repeat (5) begin
            @(negedge clk);
            chk("hold_sel_y", int'(sel_y), 1);
            chk("hold_out_valid", int'(out_valid), 1);
         end
         @(posedge clk); #1;
         out_ready = 1'b1;
      end
      wait_idle("run_back_idle");
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      in_valid  = 1'b0;
      data_in   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_wr_en_a", int'(wr_en_a), 0);
      chk("rst_wr_en_x", int'(wr_en_x), 0);
      chk("rst_wr_en_y", int'(wr_en_y), 0);
      chk("rst_clear_acc", int'(clear_acc), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr_a", int'(addr_a), 0);
      chk("rst_addr_x", int'(addr_x), 0);
      chk("rst_sel_y", int'(sel_y), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // RUN with nothing loaded, then the reserved opcode: both rejected.
      push(EV_ERR, 0, 0, 0);
      do_cmd(OP_RUN);
      repeat (3) begin
         chk("noload_busy", int'(busy), 0);
         chk("noload_clear_acc", int'(clear_acc), 0);
         @(posedge clk); #1;
      end
      push(EV_ERR, 0, 0, 0);
      do_cmd(OP_RSVD);
      @(posedge clk); #1;

      // LOAD_X with gaps and a stray command offered mid-load.
      for (int i = 0; i < K; i++) xv[i] = 8'(i + 1);
      load_x(1'b1, 1'b1);

      // Only X loaded: RUN still rejected.
      push(EV_ERR, 0, 0, 0);
      do_cmd(OP_RUN);
      @(posedge clk); #1;
      chk("x_only_busy", int'(busy), 0);

      for (int n = 0; n < K*K; n++) av[n] = 8'(n + 1);
      load_a();

      exp_y[0] = 30;
      exp_y[1] = 70;
      exp_y[2] = 110;
      exp_y[3] = 150;
      run(1'b0);
      run(1'b1);

      // All operands -128: each row sum 4*16384 wraps to 0 in 16 bits.
      for (int n = 0; n < K*K; n++) av[n] = -8'sd128;
      for (int i = 0; i < K; i++) xv[i] = -8'sd128;
      load_a();
      load_x(1'b0, 1'b0);
      for (int r = 0; r < K; r++) exp_y[r] = 0;
      run(1'b0);

      // Reset in the middle of MAC.
      do_cmd(OP_RUN);
      chk("mid_clr_clear_acc", int'(clear_acc), 1);
      @(posedge clk); #1;
      chk("mid_mac_addr_a", int'(addr_a), 1);
      reset = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_clear_acc", int'(clear_acc), 0);
      chk("midrst_addr_a", int'(addr_a), 0);
      chk("midrst_addr_x", int'(addr_x), 0);
      chk("midrst_wr_en_y", int'(wr_en_y), 0);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      push(EV_ERR, 0, 0, 0);
      do_cmd(OP_RUN);
      repeat (3) @(posedge clk);
      #1;
      chk("postrst_busy", int'(busy), 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
